// File: rtl/fc_weight_applier.sv
// fc_weight_applier: applies backprop updates to the FC layer parameter memory.
// Walks weights then biases in one flat address space, one element per cycle,
// by read-modify-write with new = sat(old - update). Reports busy/done and a
// count of saturated writes for the current or most recent pass.
module fc_weight_applier #(
  parameter int IN_DIM = 196,
  parameter int OUT_DIM = 10,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] w_rd_data,
  input  logic [DATA_W-1:0] u_rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       sat_count
);

  // Weights occupy 0..IN_DIM*OUT_DIM-1, biases follow immediately after.
  localparam int N_ELEM = IN_DIM * OUT_DIM + OUT_DIM;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);
  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] rd_cnt;
  logic              start_acc;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W:0]   diff;
  logic              diff_ovf;
  logic [DATA_W-1:0] diff_clamped;

  assign start_acc = (state == S_IDLE) && start;
  assign rd_addr   = rd_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the state-decoded strobes (busy, done, read issue).
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (!hold) begin
          rd_en = 1'b1;
          if (rd_cnt == LAST_ADDR) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Once stage 1 is empty, the last write is on the bus this cycle.
        if (!s1_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read address counter: cleared on start, advances only on issued reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rd_cnt <= '0;
    else if (start_acc) rd_cnt <= '0;
    else if (rd_en)     rd_cnt <= rd_cnt + 1'b1;
  end

  // Stage 1: track the address whose data returns from memory next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_addr <= rd_cnt;
    end
  end

  // Subtract with one guard bit, then clamp to the signed DATA_W range.
  always_comb begin
    diff         = {w_rd_data[DATA_W-1], w_rd_data} - {u_rd_data[DATA_W-1], u_rd_data};
    diff_ovf     = diff[DATA_W] ^ diff[DATA_W-1];
    diff_clamped = diff[DATA_W-1:0];
    if (diff_ovf) diff_clamped = diff[DATA_W] ? MIN_VAL : MAX_VAL;
  end

  // Stage 2: registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= s1_valid;
      if (s1_valid) begin
        wr_addr <= s1_addr;
        wr_data <= diff_clamped;
      end
    end
  end

  // Saturation counter: cleared on start, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         sat_count <= '0;
    else if (start_acc)                              sat_count <= '0;
    else if (s1_valid && diff_ovf && sat_count != '1) sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_fc_weight_applier.sv
// Directed testbench for fc_weight_applier with a behavioural memory model.
module tb_fc_weight_applier;

  localparam int N = 1970;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        busy, done, rd_en, wr_en;
  logic [10:0] rd_addr, wr_addr;
  logic [15:0] w_rd_data, u_rd_data, wr_data, sat_count;

  logic [15:0] w_mem [0:2047];
  logic [15:0] u_mem [0:2047];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;
  int n_rd, n_rd_hold, n_wr, n_done, done_rel;
  logic [15:0] sat_done;
  int          wr_addr_log [0:4095];
  logic [15:0] wr_data_log [0:4095];
  int          wr_cyc_log  [0:4095];

  fc_weight_applier #(.IN_DIM(196), .OUT_DIM(10), .DATA_W(16), .ADDR_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .w_rd_data(w_rd_data), .u_rd_data(u_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      w_rd_data <= w_mem[rd_addr];
      u_rd_data <= u_mem[rd_addr];
    end
  end

  // Recorder only; comparisons live in the test tasks.
  always @(negedge clk) begin
    if (rd_en) begin
      n_rd++;
      if (hold) n_rd_hold++;
    end
    if (wr_en) begin
      if (n_wr < 4096) begin
        wr_addr_log[n_wr] = int'(wr_addr);
        wr_data_log[n_wr] = wr_data;
        wr_cyc_log[n_wr]  = cyc - c0;
      end
      n_wr++;
    end
    if (done) begin
      n_done++;
      done_rel = cyc - c0;
      sat_done = sat_count;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    n_rd = 0; n_rd_hold = 0; n_wr = 0; n_done = 0; done_rel = -1; sat_done = '0;
  endtask

  task automatic init_basic();
    for (int a = 0; a < 2048; a++) begin
      w_mem[a] = 16'(a);
      u_mem[a] = 16'h0001;
    end
  endtask

  // Full pass: start in cycle 0 relative; optional hold window and extra starts.
  task automatic run_pass(input int hold_at, input int hold_len, input int ex1, input int ex2,
                          output bit timed_out);
    clear_log();
    tick();
    c0 = cyc;
    start = 1'b1;
    for (int r = 1; r < 2600; r++) begin
      tick();
      start = (r == ex1) || (r == ex2);
      hold  = (r >= hold_at) && (r < hold_at + hold_len);
      if (n_done > 0 && r >= done_rel + 8) break;
    end
    start = 1'b0;
    hold  = 1'b0;
    timed_out = (n_done == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
    checks++; if (rd_addr !== 11'd0) begin failures++; $display("FAIL reset_rd_addr got=%0h exp=0", rd_addr); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", wr_en); end
    checks++; if (wr_addr !== 11'd0) begin failures++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wr_data !== 16'd0) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL reset_sat_count got=%0h exp=0", sat_count); end
    start = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    bit to;
    int bad = 0, first_bad = -1;
    init_basic();
    run_pass(-100, 0, -1, -1, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (n_wr !== N) begin failures++; $display("FAIL basic_nwr got=%0d exp=%0d", n_wr, N); end
    for (int k = 0; k < N; k++) begin
      if (wr_addr_log[k] != k || wr_data_log[k] !== 16'(k - 1)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_order got=%0d_bad_first_at_%0d exp=0_bad", bad, first_bad); end
    checks++; if (wr_cyc_log[0] != 3) begin failures++; $display("FAIL basic_first_wr_cycle got=%0d exp=3", wr_cyc_log[0]); end
    checks++; if (wr_cyc_log[N-1] != N + 2) begin failures++; $display("FAIL basic_last_wr_cycle got=%0d exp=%0d", wr_cyc_log[N-1], N + 2); end
    checks++; if (done_rel != 1973) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=1973", done_rel); end
    checks++; if (sat_done !== 16'd0) begin failures++; $display("FAIL basic_sat got=%0d exp=0", sat_done); end
  endtask

  task automatic test_saturation();
    bit to;
    init_basic();
    w_mem[5] = 16'h7FFF; u_mem[5] = 16'h8000;
    w_mem[6] = 16'h8000; u_mem[6] = 16'h0001;
    run_pass(-100, 0, -1, -1, to);
    checks++; if (wr_data_log[5] !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%0h exp=7fff", wr_data_log[5]); end
    checks++; if (wr_data_log[6] !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%0h exp=8000", wr_data_log[6]); end
    checks++; if (sat_done !== 16'd2) begin failures++; $display("FAIL sat_count_done got=%0d exp=2", sat_done); end
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count_after got=%0d exp=2", sat_count); end
  endtask

  task automatic test_hold();
    bit to;
    int bad = 0;
    init_basic();
    run_pass(3, 10, -1, -1, to);
    checks++; if (n_rd_hold != 0) begin failures++; $display("FAIL hold_rd_during got=%0d exp=0", n_rd_hold); end
    checks++; if (wr_cyc_log[1] != 4) begin failures++; $display("FAIL hold_inflight_wr got=%0d exp=4", wr_cyc_log[1]); end
    checks++; if (wr_cyc_log[2] != 15) begin failures++; $display("FAIL hold_resume_wr got=%0d exp=15", wr_cyc_log[2]); end
    for (int k = 0; k < N; k++) if (wr_addr_log[k] != k) bad++;
    checks++; if (n_wr != N || bad != 0) begin failures++; $display("FAIL hold_addr_seq got=nwr%0d_bad%0d exp=nwr%0d_bad0", n_wr, bad, N); end
    checks++; if (done_rel != 1983) begin failures++; $display("FAIL hold_done_cycle got=%0d exp=1983", done_rel); end
  endtask

  task automatic test_bias();
    bit to;
    int bad = 0;
    init_basic();
    for (int a = 1960; a < 1970; a++) begin
      w_mem[a] = 16'h0000;
      u_mem[a] = 16'h0100;
    end
    run_pass(-100, 0, -1, -1, to);
    for (int k = 0; k < 10; k++)
      if (wr_addr_log[N-10+k] != 1960 + k || wr_data_log[N-10+k] !== 16'hFF00) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL bias_tail got=%0d_bad exp=0_bad", bad); end
    checks++; if (n_wr != N) begin failures++; $display("FAIL bias_nwr got=%0d exp=%0d", n_wr, N); end
  endtask

  task automatic test_start_busy();
    bit to;
    init_basic();
    run_pass(-100, 0, 700, 1973, to);
    checks++; if (n_wr != N) begin failures++; $display("FAIL busy_start_nwr got=%0d exp=%0d", n_wr, N); end
    checks++; if (n_rd != N) begin failures++; $display("FAIL busy_start_nrd got=%0d exp=%0d", n_rd, N); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL busy_start_ndone got=%0d exp=1", n_done); end
    checks++; if (done_rel != 1973) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=1973", done_rel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_cycle_start_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int nwr_at_rst;
    init_basic();
    w_mem[5] = 16'h7FFF; u_mem[5] = 16'h8000;
    clear_log();
    tick();
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 2; r <= 500; r++) tick();
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, rd_en, wr_en} !== 4'b0000) begin failures++; $display("FAIL midrst_strobes got=%4b exp=0000", {busy, done, rd_en, wr_en}); end
    checks++; if (rd_addr !== 11'd0 || wr_addr !== 11'd0) begin failures++; $display("FAIL midrst_addrs got=%0h/%0h exp=0/0", rd_addr, wr_addr); end
    checks++; if (wr_data !== 16'd0 || sat_count !== 16'd0) begin failures++; $display("FAIL midrst_data got=%0h/%0h exp=0/0", wr_data, sat_count); end
    nwr_at_rst = n_wr;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if (n_wr != nwr_at_rst) begin failures++; $display("FAIL midrst_no_wr got=%0d exp=%0d", n_wr, nwr_at_rst); end
    init_basic();
    run_pass(-100, 0, -1, -1, to);
    checks++; if (n_wr != N || wr_addr_log[0] != 0) begin failures++; $display("FAIL midrst_rerun got=nwr%0d_first%0d exp=nwr%0d_first0", n_wr, wr_addr_log[0], N); end
    checks++; if (done_rel != 1973 || sat_done !== 16'd0) begin failures++; $display("FAIL midrst_rerun_done got=cyc%0d_sat%0d exp=cyc1973_sat0", done_rel, sat_done); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_saturation();
    test_hold();
    test_bias();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
